// File: rtl/ldpc_layer_sched.sv
// Layered LDPC decoding scheduler. Walks the base-matrix ROM layer by layer,
// column by column, and hands one circulant shift per block column to the
// cyclic shifter over a valid/ready handshake. Iterations repeat until the
// syndrome checker reports success or MAX_ITER passes have been issued.
module ldpc_layer_sched #(
  parameter int mtx_w    = 8,
  parameter int ROWS     = 4,
  parameter int COLS     = 8,
  parameter int MAX_ITER = 10,
  parameter int addr_w   = 5,
  localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int LW      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int IW      = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rom_en,
  output logic [addr_w-1:0] rom_addr,
  input  logic [mtx_w-1:0]  rom_data,
  output logic [mtx_w-1:0]  shift,
  output logic              shift_vld,
  input  logic              shift_rdy,
  output logic [CW-1:0]     col_idx,
  output logic [LW-1:0]     layer_idx,
  output logic [IW-1:0]     iter_idx,
  output logic              first_col,
  output logic              last_col,
  output logic              null_blk,
  input  logic              syn_vld,
  input  logic              syn_ok,
  output logic              busy,
  output logic              done,
  output logic              converged
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_SYN, FIN} state_t;

  localparam logic [addr_w:0] TOTAL = (addr_w+1)'(ROWS * COLS);

  state_t            state;
  logic [addr_w:0]   fcnt;       // next linear ROM entry to fetch this iteration
  logic              pending;    // rom_data holds a fetched entry not yet loaded
  logic [CW-1:0]     nxt_col;    // tags of the entry that loads next
  logic [LW-1:0]     nxt_layer;

  logic load, more, acc, last_beat, syn_restart;

  // Prefetch/handshake decode; rom_en is combinational so the fetch lands
  // the cycle after it is issued and the beat register can stream at 1/cycle.
  always_comb begin
    load        = (state == RUN) && pending && (!shift_vld || shift_rdy);
    more        = fcnt < TOTAL;
    acc         = shift_vld && shift_rdy;
    last_beat   = acc && last_col && (layer_idx == LW'(ROWS - 1));
    syn_restart = (state == WAIT_SYN) && syn_vld && !syn_ok &&
                  (iter_idx != IW'(MAX_ITER - 1));
    rom_en      = !rst && (((state == IDLE) && start) || syn_restart ||
                           (load && more));
    rom_addr    = (state == RUN) ? fcnt[addr_w-1:0] : '0;
  end

  // Control FSM, fetch counter and beat register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fcnt      <= '0;
      pending   <= 1'b0;
      nxt_col   <= '0;
      nxt_layer <= '0;
      shift     <= '0;
      shift_vld <= 1'b0;
      col_idx   <= '0;
      layer_idx <= '0;
      iter_idx  <= '0;
      first_col <= 1'b0;
      last_col  <= 1'b0;
      null_blk  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
    end else begin
      done <= 1'b0;

      if (rom_en) pending <= 1'b1;
      else if (load) pending <= 1'b0;

      // Fetches from IDLE/WAIT_SYN always target address 0.
      if (rom_en) fcnt <= (state == RUN) ? fcnt + 1'b1 : (addr_w+1)'(1);

      if (load) begin
        shift     <= rom_data;
        null_blk  <= &rom_data;
        col_idx   <= nxt_col;
        layer_idx <= nxt_layer;
        first_col <= (nxt_col == '0);
        last_col  <= (nxt_col == CW'(COLS - 1));
        shift_vld <= 1'b1;
        if (nxt_col == CW'(COLS - 1)) begin
          nxt_col   <= '0;
          nxt_layer <= nxt_layer + 1'b1;
        end else begin
          nxt_col <= nxt_col + 1'b1;
        end
      end else if (acc) begin
        shift_vld <= 1'b0;
      end

      case (state)
        IDLE: if (start) begin
          state     <= RUN;
          busy      <= 1'b1;
          iter_idx  <= '0;
          converged <= 1'b0;
          nxt_col   <= '0;
          nxt_layer <= '0;
        end
        RUN: if (last_beat) state <= WAIT_SYN;
        WAIT_SYN: if (syn_vld) begin
          if (syn_ok) begin
            state     <= FIN;
            done      <= 1'b1;
            converged <= 1'b1;
          end else if (iter_idx == IW'(MAX_ITER - 1)) begin
            state     <= FIN;
            done      <= 1'b1;
            converged <= 1'b0;
          end else begin
            state     <= RUN;
            iter_idx  <= iter_idx + 1'b1;
            nxt_col   <= '0;
            nxt_layer <= '0;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_layer_sched.sv
// Directed bench for ldpc_layer_sched: 2x3 base matrix, MAX_ITER=3.
module tb_ldpc_layer_sched;
  localparam int MW = 8, R = 2, C = 3, MI = 3, AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, shift_rdy = 1'b1, syn_vld = 1'b0, syn_ok = 1'b0;
  logic rom_en, shift_vld, first_col, last_col, null_blk, busy, done, converged;
  logic [AW-1:0] rom_addr;
  logic [MW-1:0] rom_data = '0, shift;
  logic [1:0] col_idx;
  logic       layer_idx;
  logic [1:0] iter_idx;

  ldpc_layer_sched #(.mtx_w(MW), .ROWS(R), .COLS(C), .MAX_ITER(MI), .addr_w(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .shift(shift), .shift_vld(shift_vld), .shift_rdy(shift_rdy),
    .col_idx(col_idx), .layer_idx(layer_idx), .iter_idx(iter_idx),
    .first_col(first_col), .last_col(last_col), .null_blk(null_blk),
    .syn_vld(syn_vld), .syn_ok(syn_ok), .busy(busy), .done(done), .converged(converged)
  );

  always #5 clk = ~clk;

  logic [MW-1:0] rom [0:31];
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  int checks = 0, failures = 0;
  logic [MW-1:0] exp_sh [6];
  int exp_col [6], exp_lay [6], exp_first [6], exp_last [6], exp_null [6];

  logic [MW-1:0] q_sh[$];
  int q_col[$], q_lay[$], q_it[$], q_first[$], q_last[$], q_null[$], q_cyc[$];
  int stall_bad = 0, timeouts = 0, busy_start_beat = -1;
  int st_cyc; logic st_en, st_busy, g_done, g_conv, g_busy, g_vld;
  logic [AW-1:0] st_addr;

  task automatic clear_q();
    q_sh.delete(); q_col.delete(); q_lay.delete(); q_it.delete();
    q_first.delete(); q_last.delete(); q_null.delete(); q_cyc.delete();
    stall_bad = 0; timeouts = 0;
  endtask

  // Pulse start for one cycle and capture the fetch issued alongside it.
  task automatic do_start();
    @(negedge clk); start = 1'b1; shift_rdy = 1'b1; #1;
    st_cyc = cyc; st_en = rom_en; st_addr = rom_addr;
    @(negedge clk); start = 1'b0; #1;
    st_busy = busy;
  endtask

  // Accept nb beats, stalling beats sa and sb for slen cycles each.
  task automatic collect(input int nb, input int sa, input int sb, input int slen,
                         input bit syn_last);
    int ca, cb, n0, guard, k;
    bit rdy, prev_stall;
    logic [MW-1:0] s_sh; logic [1:0] s_col; logic s_lay, s_null, s_f, s_l;
    ca = 0; cb = 0; n0 = q_sh.size(); guard = 0; prev_stall = 0;
    s_sh = '0; s_col = '0; s_lay = 0; s_null = 0; s_f = 0; s_l = 0;
    while ((q_sh.size() - n0) < nb && guard < 200) begin
      @(negedge clk); guard++;
      k = q_sh.size() - n0;
      start = (k == busy_start_beat);
      rdy = 1'b1;
      if (shift_vld) begin
        if (k == sa && ca < slen) begin rdy = 1'b0; ca++; end
        else if (k == sb && cb < slen) begin rdy = 1'b0; cb++; end
      end
      shift_rdy = rdy; syn_vld = 1'b0; #1;
      if (prev_stall && (shift !== s_sh || col_idx !== s_col || layer_idx !== s_lay ||
                         null_blk !== s_null || first_col !== s_f || last_col !== s_l ||
                         shift_vld !== 1'b1))
        stall_bad++;
      if (shift_vld && !rdy && rom_en !== 1'b0) stall_bad++;
      prev_stall = shift_vld && !rdy;
      s_sh = shift; s_col = col_idx; s_lay = layer_idx; s_null = null_blk;
      s_f = first_col; s_l = last_col;
      if (shift_vld && rdy) begin
        q_sh.push_back(shift); q_col.push_back(int'(col_idx)); q_lay.push_back(int'(layer_idx));
        q_it.push_back(int'(iter_idx)); q_first.push_back(int'(first_col));
        q_last.push_back(int'(last_col)); q_null.push_back(int'(null_blk)); q_cyc.push_back(cyc);
        if (syn_last && k == nb - 1) begin syn_vld = 1'b1; syn_ok = 1'b1; end
      end
    end
    start = 1'b0;
    if (guard >= 200) timeouts++;
  endtask

  // One-cycle syndrome report; observe the cycle right after it is sampled.
  task automatic give_syn(input bit ok);
    @(negedge clk); syn_vld = 1'b1; syn_ok = ok;
    @(negedge clk); syn_vld = 1'b0; syn_ok = 1'b0; #1;
    g_done = done; g_conv = converged; g_busy = busy; g_vld = shift_vld;
  endtask

  task automatic test_reset();
    rst = 1'b1; repeat (2) @(negedge clk); #1;
    checks++;
    if ({shift_vld, rom_en, done, converged, busy} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {shift_vld, rom_en, done, converged, busy});
    end
    checks++;
    if ({shift, rom_addr, col_idx, layer_idx, iter_idx} !== '0) begin
      failures++; $display("FAIL reset_data shift=%0h addr=%0h col=%0d lay=%0d it=%0d exp=0",
                           shift, rom_addr, col_idx, layer_idx, iter_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_converge();
    int d0;
    clear_q(); do_start();
    checks++;
    if (st_en !== 1'b1 || st_addr !== '0 || st_busy !== 1'b1) begin
      failures++; $display("FAIL start_fetch en=%b addr=%0d busy=%b exp en=1 addr=0 busy=1", st_en, st_addr, st_busy);
    end
    collect(6, -1, -1, 0, 0);
    checks++;
    if (q_sh.size() != 6 || timeouts != 0) begin
      failures++; $display("FAIL conv_count got=%0d exp=6 timeouts=%0d", q_sh.size(), timeouts);
    end
    for (int i = 0; i < q_sh.size() && i < 6; i++) begin
      checks++;
      if (q_sh[i] !== exp_sh[i] || q_col[i] != exp_col[i] || q_lay[i] != exp_lay[i] ||
          q_first[i] != exp_first[i] || q_last[i] != exp_last[i] || q_null[i] != exp_null[i] ||
          q_it[i] != 0) begin
        failures++;
        $display("FAIL conv_beat%0d got sh=%0h c=%0d l=%0d f=%0d la=%0d n=%0d it=%0d exp sh=%0h c=%0d l=%0d f=%0d la=%0d n=%0d it=0",
                 i, q_sh[i], q_col[i], q_lay[i], q_first[i], q_last[i], q_null[i], q_it[i],
                 exp_sh[i], exp_col[i], exp_lay[i], exp_first[i], exp_last[i], exp_null[i]);
      end
      checks++;
      if (q_cyc[i] != st_cyc + 2 + i) begin
        failures++; $display("FAIL conv_timing%0d got=%0d exp=%0d", i, q_cyc[i] - st_cyc, 2 + i);
      end
    end
    d0 = done_cnt;
    give_syn(1'b1);
    checks++;
    if (g_done !== 1'b1 || g_conv !== 1'b1 || g_vld !== 1'b0) begin
      failures++; $display("FAIL conv_done done=%b conv=%b vld=%b exp 1 1 0", g_done, g_conv, g_vld);
    end
    repeat (2) @(negedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || converged !== 1'b1 || done_cnt - d0 != 1) begin
      failures++; $display("FAIL conv_after done=%b busy=%b conv=%b pulses=%0d exp 0 0 1 1",
                           done, busy, converged, done_cnt - d0);
    end
  endtask

  task automatic test_backpressure();
    clear_q(); do_start();
    collect(6, 1, 4, 3, 0);
    checks++;
    if (stall_bad != 0 || timeouts != 0) begin
      failures++; $display("FAIL bp_stall_hold bad=%0d timeouts=%0d exp 0 0", stall_bad, timeouts);
    end
    checks++;
    if (q_sh.size() != 6) begin
      failures++; $display("FAIL bp_count got=%0d exp=6", q_sh.size());
    end
    for (int i = 0; i < q_sh.size() && i < 6; i++) begin
      checks++;
      if (q_sh[i] !== exp_sh[i] || q_col[i] != exp_col[i] || q_lay[i] != exp_lay[i]) begin
        failures++; $display("FAIL bp_beat%0d got sh=%0h c=%0d l=%0d exp sh=%0h c=%0d l=%0d",
                             i, q_sh[i], q_col[i], q_lay[i], exp_sh[i], exp_col[i], exp_lay[i]);
      end
    end
    checks++;
    if (q_sh.size() == 6 && (q_cyc[1] - q_cyc[0] != 4 || q_cyc[4] - q_cyc[3] != 4)) begin
      failures++; $display("FAIL bp_gap got=%0d,%0d exp=4,4", q_cyc[1] - q_cyc[0], q_cyc[4] - q_cyc[3]);
    end
    give_syn(1'b1);
    checks++;
    if (g_done !== 1'b1 || g_conv !== 1'b1) begin
      failures++; $display("FAIL bp_done done=%b conv=%b exp 1 1", g_done, g_conv);
    end
    @(negedge clk);
  endtask

  task automatic test_max_iter();
    int bad;
    clear_q(); do_start();
    for (int it = 0; it < 3; it++) begin
      collect(6, -1, -1, 0, 0);
      bad = 0;
      for (int i = 0; i < 6; i++)
        if (q_sh.size() != 6 * (it + 1) || q_it[6*it+i] != it || q_sh[6*it+i] !== exp_sh[i]) bad++;
      checks++;
      if (bad != 0 || timeouts != 0) begin
        failures++; $display("FAIL maxit_pass%0d bad=%0d timeouts=%0d exp 0 0", it, bad, timeouts);
      end
      give_syn(1'b0);
      checks++;
      if (it < 2 && (g_done !== 1'b0 || g_busy !== 1'b1)) begin
        failures++; $display("FAIL maxit_cont%0d done=%b busy=%b exp 0 1", it, g_done, g_busy);
      end else if (it == 2 && (g_done !== 1'b1 || g_conv !== 1'b0)) begin
        failures++; $display("FAIL maxit_done done=%b conv=%b exp 1 0", g_done, g_conv);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_early_term();
    int extra;
    clear_q(); do_start();
    collect(6, -1, -1, 0, 0);
    give_syn(1'b0);
    collect(6, -1, -1, 0, 0);
    give_syn(1'b1);
    checks++;
    if (g_done !== 1'b1 || g_conv !== 1'b1) begin
      failures++; $display("FAIL early_done done=%b conv=%b exp 1 1", g_done, g_conv);
    end
    extra = 0;
    repeat (6) begin @(negedge clk); #1; if (shift_vld) extra++; end
    checks++;
    if (q_sh.size() != 12 || extra != 0 || q_it[0] != 0 || q_it[11] != 1 || q_sh[6] !== exp_sh[0]) begin
      failures++; $display("FAIL early_beats got=%0d extra=%0d exp 12 0", q_sh.size(), extra);
    end
  endtask

  task automatic test_late_syn();
    int d0;
    clear_q(); do_start();
    d0 = done_cnt;
    collect(6, -1, -1, 0, 1);
    @(negedge clk); syn_vld = 1'b0; syn_ok = 1'b0;
    repeat (2) @(negedge clk); #1;
    checks++;
    if (done_cnt != d0 || busy !== 1'b1) begin
      failures++; $display("FAIL late_syn_ignored pulses=%0d busy=%b exp 0 1", done_cnt - d0, busy);
    end
    give_syn(1'b1);
    checks++;
    if (g_done !== 1'b1) begin
      failures++; $display("FAIL late_syn_done done=%b exp 1", g_done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int d0;
    clear_q(); do_start();
    collect(4, -1, -1, 0, 0);
    d0 = done_cnt;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (shift_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rom_en !== 1'b0) begin
      failures++; $display("FAIL rstmid_state vld=%b busy=%b done=%b en=%b exp 0 0 0 0",
                           shift_vld, busy, done, rom_en);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    clear_q(); do_start();
    checks++;
    if (st_en !== 1'b1 || st_addr !== '0 || done_cnt != d0) begin
      failures++; $display("FAIL rstmid_restart en=%b addr=%0d pulses=%0d exp 1 0 0", st_en, st_addr, done_cnt - d0);
    end
    collect(6, -1, -1, 0, 0);
    checks++;
    if (q_sh.size() != 6 || q_sh[0] !== 8'h03 || q_it[0] != 0 || q_col[0] != 0 || q_lay[0] != 0 ||
        q_sh[5] !== 8'h02) begin
      failures++; $display("FAIL rstmid_first got n=%0d it=%0d exp n=6 sh0=03 it=0", q_sh.size(),
                           q_it.size() > 0 ? q_it[0] : -1);
    end
    give_syn(1'b1);
    @(negedge clk);
  endtask

  task automatic test_start_busy();
    int d0, bad;
    clear_q(); d0 = done_cnt;
    busy_start_beat = 2;
    do_start();
    collect(6, -1, -1, 0, 0);
    busy_start_beat = -1;
    bad = 0;
    for (int i = 0; i < 6; i++) if (q_sh.size() != 6 || q_sh[i] !== exp_sh[i] || q_col[i] != exp_col[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL startbusy_stream bad=%0d exp 0", bad);
    end
    give_syn(1'b1);
    repeat (4) @(negedge clk); #1;
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      failures++; $display("FAIL startbusy_done pulses=%0d busy=%b exp 1 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_start_rst();
    @(negedge clk); rst = 1'b1; start = 1'b1; #1;
    checks++;
    if (rom_en !== 1'b0) begin
      failures++; $display("FAIL startrst_en got=%b exp 0", rom_en);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || shift_vld !== 1'b0 || rom_en !== 1'b0) begin
      failures++; $display("FAIL startrst_idle busy=%b vld=%b en=%b exp 0 0 0", busy, shift_vld, rom_en);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = '0;
    rom[0] = 8'h03; rom[1] = 8'h00; rom[2] = 8'hFF; rom[3] = 8'h01; rom[4] = 8'h04; rom[5] = 8'h02;
    exp_sh    = '{8'h03, 8'h00, 8'hFF, 8'h01, 8'h04, 8'h02};
    exp_col   = '{0, 1, 2, 0, 1, 2};
    exp_lay   = '{0, 0, 0, 1, 1, 1};
    exp_first = '{1, 0, 0, 1, 0, 0};
    exp_last  = '{0, 0, 1, 0, 0, 1};
    exp_null  = '{0, 0, 1, 0, 0, 0};
    test_reset();
    test_converge();
    test_backpressure();
    test_max_iter();
    test_early_term();
    test_late_syn();
    test_reset_mid();
    test_start_busy();
    test_start_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached exp finish");
    $fatal(1);
  end
endmodule
